// File: rtl/spi_master.sv
// spi_master: single-slave SPI master, one DATA_WIDTH word per frame, MSB first, all four CPOL/CPHA modes
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   clk_div_i [7:0]      SCLK half-period in clk cycles (0 behaves as 1)
//   cpol_i, cpha_i       SPI mode, latched at accept
//   tx_data_i            word to send, latched on tx_valid_i && tx_ready_o
//   tx_valid_i/tx_ready_o  request / idle-and-accepting handshake
//   rx_data_o            last fully received word
//   spi_mosi_o, spi_miso_i, spi_sclk_o, spi_ss_n_o  serial interface
module spi_master #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            clk_div_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i,
  output logic                  spi_sclk_o,
  output logic                  spi_ss_n_o
);
  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam int KW = EW - 1;
  localparam logic [KW-1:0] KMAX = KW'(DATA_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;
  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d, h_q, h_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, sh_q, sh_d, rx_q, rx_d;
  logic                  tick, sample, last_edge;
  logic [KW-1:0]         k, idx;
  assign tick = cnt_q == h_q - 8'd1;
  // k is the bit slot of the current edge; even edges are leading, odd edges trailing
  assign k = edge_q[EW-1:1];
  assign last_edge = edge_q == EW'(2 * DATA_WIDTH - 1);
  // sample on leading edges for cpha=0, trailing edges for cpha=1
  assign sample = edge_q[0] == cpha_q;
  // cpha=0 drives the following bit on a trailing edge, cpha=1 drives the current bit on a leading edge
  assign idx = KMAX - k - KW'(!cpha_q);
  assign tx_ready_o = state_q == IDLE;
  assign spi_ss_n_o = state_q == IDLE;
  assign spi_sclk_o = state_q == IDLE ? cpol_i : sclk_q;
  assign spi_mosi_o = mosi_q;
  assign rx_data_o = rx_q;
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
    h_d = h_q;
    edge_d = edge_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    tx_d = tx_q;
    sh_d = sh_q;
    rx_d = rx_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (tx_valid_i) begin
          state_d = SETUP;
          edge_d = '0;
          h_d = clk_div_i == 8'd0 ? 8'd1 : clk_div_i;
          cpol_d = cpol_i;
          cpha_d = cpha_i;
          sclk_d = cpol_i;
          tx_d = tx_data_i;
          mosi_d = tx_data_i[DATA_WIDTH-1];
        end
      end
      SETUP: state_d = tick ? XFER : SETUP;
      XFER: if (tick) begin
        sclk_d = ~sclk_q;
        edge_d = edge_q + EW'(1);
        if (sample) sh_d = {sh_q[DATA_WIDTH-2:0], spi_miso_i};
        else if (cpha_q || k != KMAX) mosi_d = tx_q[idx];
        state_d = last_edge ? HOLD : XFER;
      end
      HOLD: if (tick) begin
        state_d = IDLE;
        rx_d = sh_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      h_q <= 8'd1;
      edge_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      tx_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      h_q <= h_d;
      edge_q <= edge_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      tx_q <= tx_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: random and directed SPI frames against a slave-side reference model
module tb_spi_master;
  localparam int DW = 8;
  logic          clk = 0, rst_n = 0;
  logic [7:0]    clk_div = 0;
  logic          cpol = 0, cpha = 0, tx_valid = 0, tx_ready;
  logic [DW-1:0] tx_data = 0, rx_data;
  logic          mosi, miso, sclk, ss_n;
  logic          slave_miso = 0, loop = 0;
  int            vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  assign miso = loop ? mosi : slave_miso;
  spi_master #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_div_i(clk_div), .cpol_i(cpol), .cpha_i(cpha),
    .tx_data_i(tx_data), .rx_data_o(rx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .spi_mosi_o(mosi), .spi_miso_i(miso), .spi_sclk_o(sclk), .spi_ss_n_o(ss_n)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // slave model: what an SPI slave of the frame's mode would see and send
  logic [DW-1:0] slave_word = 0, got_mosi = 0;
  logic          fpol = 0, fpha = 0, prev_ss = 1, prev_sclk = 0, lead;
  int            n_edges = 0, n_lead = 0, low_cyc = 0, since = 0, min_iv = 0, max_iv = 0;
  int            smp = 0, drv = 0, frames = 0;
  always @(negedge clk) begin
    if (!ss_n) begin
      if (prev_ss) begin
        n_edges = 0; n_lead = 0; low_cyc = 0; since = 0; min_iv = 1000; max_iv = 0;
        got_mosi = 0; smp = 0; drv = 0; frames++;
        if (!fpha) begin
          slave_miso = slave_word[DW-1];
          drv = 1;
        end
      end
      low_cyc++;
      since++;
      if (!prev_ss && sclk !== prev_sclk) begin
        lead = sclk != fpol;
        if (lead) n_lead++;
        if (n_edges > 0) begin
          if (since < min_iv) min_iv = since;
          if (since > max_iv) max_iv = since;
        end
        since = 0;
        n_edges++;
        if (lead != fpha) begin
          got_mosi = {got_mosi[DW-2:0], mosi};
          smp++;
        end else if (drv < DW) begin
          slave_miso = slave_word[DW-1-drv];
          drv++;
        end
      end
    end
    prev_ss = ss_n;
    prev_sclk = sclk;
  end
  task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input logic [7:0] div,
                           input logic pol, input logic pha, input logic lb, input logic poke);
    int t, f0;
    int h = div == 0 ? 1 : int'(div);
    fpol = pol; fpha = pha; slave_word = sw; loop = lb;
    clk_div = div; cpol = pol; cpha = pha; tx_data = tx;
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk); #1; t++;
    end
    chk("ready_wait", {31'd0, tx_ready}, 1);
    f0 = frames;
    tx_valid = 1;
    @(negedge clk); #1;
    if (poke) begin
      tx_data = ~tx; cpol = !pol; cpha = !pha; clk_div = div + 8'd3;
      repeat (10) @(negedge clk);
      #1;
    end
    tx_valid = 0;
    t = 0;
    while (!ss_n && t < 5000) begin
      @(negedge clk); #1; t++;
    end
    chk("frames", frames, f0 + 1);
    chk("ready_end", {31'd0, tx_ready}, 1);
    chk("rx_data", {24'd0, rx_data}, {24'd0, lb ? tx : sw});
    chk("mosi_bits", {24'd0, got_mosi}, {24'd0, tx});
    chk("sclk_edges", n_edges, 2 * DW);
    chk("sclk_pulses", n_lead, DW);
    chk("ss_low_cycles", low_cyc, (2 * DW + 2) * h);
    chk("half_period_min", min_iv, h);
    chk("half_period_max", max_iv, h);
    chk("sclk_idle", {31'd0, sclk}, {31'd0, cpol});
    if (poke) begin
      repeat (20) @(negedge clk);
      #1;
      chk("busy_ignored", frames, f0 + 1);
      chk("ss_idle", {31'd0, ss_n}, 1);
    end
  endtask
  initial begin
    int t;
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, tx_ready}, 1);
    chk("rst_ss_n", {31'd0, ss_n}, 1);
    chk("rst_sclk", {31'd0, sclk}, 0);
    chk("rst_mosi", {31'd0, mosi}, 0);
    chk("rst_rx", {24'd0, rx_data}, 0);
    rst_n = 1;
    @(negedge clk); #1;
    run_frame(8'hA5, 8'h3C, 8'd4, 0, 0, 0, 0);
    run_frame(8'h5A, 8'hC3, 8'd4, 0, 0, 0, 0);
    for (int m = 0; m < 4; m++) run_frame(8'h96, 8'h00, 8'd3, m[1], m[0], 1, 0);
    run_frame(8'h3B, 8'hE1, 8'd0, 0, 1, 0, 1);
    run_frame(8'hC4, 8'h17, 8'd1, 1, 0, 0, 1);
    for (int i = 0; i < 16; i++)
      run_frame(DW'($urandom), DW'($urandom), 8'($urandom_range(0, 5)), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
    run_frame(8'h81, 8'h00, 8'd2, 0, 0, 0, 0);
    slave_word = 8'h5E; loop = 0; fpol = 0; fpha = 0;
    cpol = 0; cpha = 0; clk_div = 8'd2; tx_data = 8'hF0; tx_valid = 1;
    @(negedge clk); #1;
    tx_valid = 0;
    t = 0;
    while (smp < 3 && t < 500) begin
      @(negedge clk); #1; t++;
    end
    chk("abort_bits", {31'd0, smp >= 3}, 1);
    rst_n = 0;
    #1;
    chk("abort_ss_n", {31'd0, ss_n}, 1);
    chk("abort_ready", {31'd0, tx_ready}, 1);
    chk("abort_rx", {24'd0, rx_data}, 0);
    chk("abort_sclk", {31'd0, sclk}, 0);
    @(negedge clk); #1;
    rst_n = 1;
    run_frame(8'h69, 8'hB2, 8'd2, 1, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
